// File: rtl/enigma_pkg.sv
// enigma_pkg: letter index type, rotor/reflector/plugboard wirings and ASCII helpers.
// ENIGMA_PLUGBOARD_EN selects the plugboard swaps; otherwise the plugboard is the identity.
package enigma_pkg;
   localparam int NUM_LETTERS = 26;
   localparam int POS_W = 5;
   typedef logic [POS_W-1:0] idx_t;
   typedef idx_t wiring_t [0:NUM_LETTERS-1];
   localparam idx_t LAST = idx_t'(NUM_LETTERS - 1);
   localparam logic [POS_W:0] MOD = (POS_W+1)'(NUM_LETTERS);
   localparam wiring_t R1_FWD = '{
      5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
      5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9};
   localparam wiring_t R1_INV = '{
      5'd20, 5'd22, 5'd24, 5'd6, 5'd0, 5'd3, 5'd5, 5'd15, 5'd21, 5'd25, 5'd1, 5'd4, 5'd2,
      5'd10, 5'd12, 5'd19, 5'd7, 5'd23, 5'd18, 5'd11, 5'd17, 5'd8, 5'd13, 5'd16, 5'd14, 5'd9};
   localparam wiring_t R2_FWD = '{
      5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1, 5'd11, 5'd7, 5'd22,
      5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4};
   localparam wiring_t R2_INV = '{
      5'd0, 5'd9, 5'd15, 5'd2, 5'd25, 5'd22, 5'd17, 5'd11, 5'd5, 5'd1, 5'd3, 5'd10, 5'd14,
      5'd19, 5'd24, 5'd20, 5'd16, 5'd6, 5'd4, 5'd13, 5'd7, 5'd23, 5'd12, 5'd8, 5'd21, 5'd18};
   localparam wiring_t R3_FWD = '{
      5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
      5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd14, 5'd20, 5'd18, 5'd16};
   localparam wiring_t R3_INV = '{
      5'd19, 5'd0, 5'd6, 5'd1, 5'd15, 5'd2, 5'd18, 5'd3, 5'd16, 5'd4, 5'd20, 5'd5, 5'd21,
      5'd13, 5'd22, 5'd7, 5'd25, 5'd8, 5'd24, 5'd9, 5'd23, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};
   localparam wiring_t REFL = '{
      5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15, 5'd23, 5'd13, 5'd6, 5'd14,
      5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2, 5'd22, 5'd21, 5'd9, 5'd0, 5'd19};
`ifdef ENIGMA_PLUGBOARD_EN
   localparam wiring_t PLUG = '{
      5'd4, 5'd5, 5'd12, 5'd16, 5'd0, 5'd1, 5'd6, 5'd20, 5'd8, 5'd13, 5'd10, 5'd23, 5'd2,
      5'd9, 5'd14, 5'd17, 5'd3, 5'd15, 5'd25, 5'd19, 5'd7, 5'd22, 5'd21, 5'd11, 5'd24, 5'd18};
`else
   localparam wiring_t PLUG = '{
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12,
      5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25};
`endif
   function automatic logic is_letter(input logic [7:0] c);
      return c >= 8'h41 && c <= 8'h5A;
   endfunction
   function automatic idx_t to_idx(input logic [7:0] c);
      logic [7:0] d;
      d = c - 8'h41;
      return d[POS_W-1:0];
   endfunction
   function automatic logic [7:0] to_ascii(input idx_t i);
      return {3'b000, i} + 8'h41;
   endfunction
   // Also folds raw 26..31 back into range when b is zero
   function automatic idx_t add_mod(input idx_t a, input idx_t b);
      logic [POS_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      s = s >= MOD ? s - MOD : s;
      return s[POS_W-1:0];
   endfunction
   function automatic idx_t sub_mod(input idx_t a, input idx_t b);
      logic [POS_W:0] s;
      s = {1'b0, a} + MOD - {1'b0, b};
      s = s >= MOD ? s - MOD : s;
      return s[POS_W-1:0];
   endfunction
endpackage

// File: rtl/enigma_machine.sv
// enigma_machine: one three-rotor machine with odometer stepping and a zero-latency cipher path.
// Plugboard contents depend on ENIGMA_PLUGBOARD_EN (see enigma_pkg).
module enigma_machine
   import enigma_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [POS_W-1:0] start1,
   input  logic [POS_W-1:0] start2,
   input  logic [POS_W-1:0] start3,
   input  logic [7:0]       char_in,
   output logic [7:0]       char_out
);
   idx_t pos1, pos2, pos3, x;
   logic letter;
   assign letter = is_letter(char_in);
   always_ff @(posedge clk) begin
      if (rst) begin
         pos1 <= '0;
         pos2 <= '0;
         pos3 <= '0;
      end else if (load) begin
         pos1 <= add_mod(start1, 5'd0);
         pos2 <= add_mod(start2, 5'd0);
         pos3 <= add_mod(start3, 5'd0);
      end else if (letter) begin
         pos1 <= add_mod(pos1, 5'd1);
         if (pos1 == LAST) pos2 <= add_mod(pos2, 5'd1);
         if (pos1 == LAST && pos2 == LAST) pos3 <= add_mod(pos3, 5'd1);
      end
   end
   // Enciphers with the pre-step positions; non-letters bypass the rotors
   always_comb begin
      x = PLUG[letter ? to_idx(char_in) : 5'd0];
      x = sub_mod(R1_FWD[add_mod(x, pos1)], pos1);
      x = sub_mod(R2_FWD[add_mod(x, pos2)], pos2);
      x = sub_mod(R3_FWD[add_mod(x, pos3)], pos3);
      x = REFL[x];
      x = sub_mod(R3_INV[add_mod(x, pos3)], pos3);
      x = sub_mod(R2_INV[add_mod(x, pos2)], pos2);
      x = sub_mod(R1_INV[add_mod(x, pos1)], pos1);
      x = PLUG[x];
      char_out = letter ? to_ascii(x) : char_in;
   end
endmodule

// File: rtl/enigma_communication.sv
// enigma_communication: encryptor/decryptor loopback of two lock-stepped Enigma machines.
// Build with ENIGMA_PLUGBOARD_EN to enable the plugboard in both machines.
module enigma_communication
   import enigma_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic [7:0]       plainChar,
   input  logic [POS_W-1:0] startPosition1,
   input  logic [POS_W-1:0] startPosition2,
   input  logic [POS_W-1:0] startPosition3,
   input  logic             load,
   output logic [7:0]       chipherChar,
   output logic [7:0]       decryptedChar
);
   enigma_machine u_enc (
      .clk(clock), .rst(reset), .load(load),
      .start1(startPosition1), .start2(startPosition2), .start3(startPosition3),
      .char_in(plainChar), .char_out(chipherChar)
   );
   enigma_machine u_dec (
      .clk(clock), .rst(reset), .load(load),
      .start1(startPosition1), .start2(startPosition2), .start3(startPosition3),
      .char_in(chipherChar), .char_out(decryptedChar)
   );
endmodule

// File: tb/tb_enigma_communication.sv
// tb_enigma_communication: directed scoreboard bench against a string-table Enigma model.
// Expectations follow ENIGMA_PLUGBOARD_EN the same way the design does.
module tb_enigma_communication;
   logic clock = 1'b0;
   logic reset, load;
   logic [7:0] plainChar, chipherChar, decryptedChar;
   logic [4:0] startPosition1, startPosition2, startPosition3;
   int total = 0, bad = 0;
   int m1 = 0, m2 = 0, m3 = 0;
   logic [15:0] sb[$];
   string R1 = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
   string R2 = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
   string R3 = "BDFHJLCPRTXVZNYEIWGAKMOUSQ";
   string RF = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
   string PAIRS = "AEBFCMDQHUJNLXPRSZVW";
`ifdef ENIGMA_PLUGBOARD_EN
   localparam logic [7:0] EXP_A = 8'h55;
`else
   localparam logic [7:0] EXP_A = 8'h4E;
`endif

   always #5 clock = ~clock;

   enigma_communication dut (
      .clock(clock), .reset(reset), .plainChar(plainChar),
      .startPosition1(startPosition1), .startPosition2(startPosition2),
      .startPosition3(startPosition3), .load(load),
      .chipherChar(chipherChar), .decryptedChar(decryptedChar)
   );

   function automatic int plug(input int x);
`ifdef ENIGMA_PLUGBOARD_EN
      for (int k = 0; k < 10; k++) begin
         if (x == int'(PAIRS[2*k]) - 65) return int'(PAIRS[2*k+1]) - 65;
         if (x == int'(PAIRS[2*k+1]) - 65) return int'(PAIRS[2*k]) - 65;
      end
`endif
      return x;
   endfunction

   function automatic int fw(input string w, input int x, input int p);
      return (int'(w[(x + p) % 26]) - 65 - p + 26) % 26;
   endfunction

   function automatic int bw(input string w, input int x, input int p);
      for (int j = 0; j < 26; j++)
         if (int'(w[j]) - 65 == (x + p) % 26) return (j - p + 26) % 26;
      return 0;
   endfunction

   function automatic logic [7:0] model(input logic [7:0] c);
      int x;
      if (c < 8'h41 || c > 8'h5A) return c;
      x = plug(int'(c) - 65);
      x = fw(R1, x, m1);
      x = fw(R2, x, m2);
      x = fw(R3, x, m3);
      x = int'(RF[x]) - 65;
      x = bw(R3, x, m3);
      x = bw(R2, x, m2);
      x = bw(R1, x, m1);
      return 8'(plug(x) + 65);
   endfunction

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_pos(input string tag, input int p1, input int p2, input int p3);
      logic [29:0] obs, exp;
      obs = {dut.u_enc.pos3, dut.u_enc.pos2, dut.u_enc.pos1,
             dut.u_dec.pos3, dut.u_dec.pos2, dut.u_dec.pos1};
      exp = {5'(p3), 5'(p2), 5'(p1), 5'(p3), 5'(p2), 5'(p1)};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive, predict, compare at the falling edge, then advance the model
   task automatic apply(input string tag, input logic [7:0] c, input logic rs, input logic ld,
                        input int s1, input int s2, input int s3);
      logic [15:0] e;
      plainChar = c;
      reset = rs;
      load = ld;
      startPosition1 = 5'(s1);
      startPosition2 = 5'(s2);
      startPosition3 = 5'(s3);
      sb.push_back({model(c), c});
      @(negedge clock);
      e = sb.pop_front();
      check8({tag, ".cipher"}, chipherChar, e[15:8]);
      check8({tag, ".decrypt"}, decryptedChar, e[7:0]);
      @(posedge clock);
      if (rs) begin
         m1 = 0; m2 = 0; m3 = 0;
      end else if (ld) begin
         m1 = s1 % 26; m2 = s2 % 26; m3 = s3 % 26;
      end else if (c >= 8'h41 && c <= 8'h5A) begin
         m1 = (m1 + 1) % 26;
         if (m1 == 0) begin
            m2 = (m2 + 1) % 26;
            if (m2 == 0) m3 = (m3 + 1) % 26;
         end
      end
      #1;
   endtask

   initial begin
      string msg;
      msg = "SAXELRWL";
      reset = 1'b1;
      load = 1'b0;
      plainChar = 8'h41;
      startPosition1 = '0;
      startPosition2 = '0;
      startPosition3 = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      check_pos("reset_pos", 0, 0, 0);
      plainChar = 8'h41;
      #1;
      check8("a_at_000", chipherChar, EXP_A);
      check8("a_at_000_dec", decryptedChar, 8'h41);
      plainChar = EXP_A;
      #1;
      check8("reciprocal", chipherChar, 8'h41);
      for (int i = 0; i < 3; i++) apply("hold_a", 8'h41, 1'b0, 1'b0, 0, 0, 0);
      check_pos("hold_a_pos", 3, 0, 0);
      apply("load_10_3_4", 8'h41, 1'b0, 1'b1, 10, 3, 4);
      check_pos("load_no_step", 10, 3, 4);
      for (int i = 0; i < 8; i++) apply("msg", msg[i], 1'b0, 1'b0, 0, 0, 0);
      apply("load_25_0_0", 8'h51, 1'b0, 1'b1, 25, 0, 0);
      apply("carry1", 8'h51, 1'b0, 1'b0, 0, 0, 0);
      check_pos("carry1_pos", 0, 1, 0);
      apply("after_carry1", 8'h4B, 1'b0, 1'b0, 0, 0, 0);
      apply("load_25_25_25", 8'h4D, 1'b0, 1'b1, 25, 25, 25);
      apply("carry3", 8'h4D, 1'b0, 1'b0, 0, 0, 0);
      check_pos("carry3_pos", 0, 0, 0);
      apply("after_carry3", 8'h42, 1'b0, 1'b0, 0, 0, 0);
      apply("space", 8'h20, 1'b0, 1'b0, 0, 0, 0);
      check_pos("space_no_step", 1, 0, 0);
      apply("lower_a", 8'h61, 1'b0, 1'b0, 0, 0, 0);
      check_pos("lower_no_step", 1, 0, 0);
      apply("rst_and_load", 8'h43, 1'b1, 1'b1, 7, 8, 9);
      check_pos("rst_wins", 0, 0, 0);
      apply("load_wrap", 8'h5A, 1'b0, 1'b1, 31, 30, 26);
      check_pos("wrap_pos", 5, 4, 0);
      for (int i = 0; i < 30; i++)
         apply("run", 8'(65 + (i * 7) % 26), 1'b0, 1'b0, 0, 0, 0);
      check_pos("run_pos", 9, 5, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
